// File: rtl/coeff_frame_deserializer.sv
// coeff_frame_deserializer
//
// Collects D consecutive W-bit coefficients from a valid/ready input stream into one packed
// frame and presents it, registered, on a valid/ready output. It feeds the bit-reverse
// permutation stage. Coefficient k (the k-th accepted, k = 0..D-1) sits at
// out_data[k*W +: W], so the frame is in natural (arrival) order.
//
// The block has two frame buffers. The fill buffer assembles the incoming frame, and the
// output register holds the presented frame. With out_ready held high, one frame per D cycles
// streams through with no gaps.
//
// Ports:
//   clk        clock; every register updates on the rising edge
//   rst        synchronous, active-high reset
//   in_data    coefficient (W bits)
//   in_valid   in_data is valid
//   in_last    final coefficient of a frame; sampled only on accept
//   in_ready   block can accept a coefficient (registered, no path from out_ready)
//   out_data   packed frame (D*W bits)
//   out_valid  out_data holds a complete frame
//   out_ready  downstream accepts the frame
//   err        sticky framing error (early or missing in_last); cleared only by rst

module coeff_frame_deserializer #(
  parameter int unsigned W  = 9,
  parameter int unsigned D  = 8,
  parameter int unsigned CW = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [D*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err
);

  logic [W-1:0]   fill_q [D];
  logic [CW-1:0]  count_q;
  logic           fill_full_q;
  logic [D*W-1:0] out_data_q;
  logic           out_valid_q;
  logic           err_q;

  logic           accept;
  logic           last_slot;
  logic           frame_done;
  logic           early_last;
  logic           slot_free;
  logic [D*W-1:0] frame_fill;
  logic [D*W-1:0] frame_new;

  assign in_ready  = ~fill_full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

  always_comb begin
    accept     = in_valid & ~fill_full_q;
    last_slot  = (count_q == CW'(D - 1));
    frame_done = accept & last_slot;
    early_last = accept & in_last & ~last_slot;
    slot_free  = ~out_valid_q | out_ready;

    // frame_fill is the held frame. frame_new is the frame that completes this cycle:
    // its last slot comes from the input bus because fill_q[D-1] is only written at this edge.
    frame_fill = '0;
    for (int k = 0; k < D; k++) begin
      frame_fill[k*W +: W] = fill_q[k];
    end
    frame_new = frame_fill;
    frame_new[(D-1)*W +: W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        fill_q[k] <= '0;
      end
      count_q     <= '0;
      fill_full_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        fill_q[count_q] <= in_data;
        // An early last drops the partial frame, so the next coefficient starts a fresh frame.
        if (early_last || last_slot) begin
          count_q <= '0;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end

      if (early_last || (frame_done && !in_last)) begin
        err_q <= 1'b1;
      end

      // While a frame is held, in_ready is low, so frame_done cannot fire in the same cycle.
      if (fill_full_q) begin
        if (out_ready) begin
          out_data_q  <= frame_fill;
          fill_full_q <= 1'b0;
        end
      end else if (frame_done) begin
        if (slot_free) begin
          out_data_q  <= frame_new;
          out_valid_q <= 1'b1;
        end else begin
          fill_full_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/coeff_frame_deserializer.md
Name: coeff_frame_deserializer

Overview:
- Upstream feeder for the bit-reverse permutation stage.
- Accepts polynomial coefficients one per cycle on a valid/ready stream and assembles D consecutive coefficients into one packed frame.
- Presents the frame, registered and in natural (arrival) order, on a valid/ready output whose data bus drives the permutation stage's D*W-bit input.
- Two frame buffers (fill + output) give gap-free streaming under continuous output acceptance.

Parameters:
W, 9, coefficient width in bits
D, 8, coefficients per frame; power of two, D >= 2
CW, $clog2(D), width of the internal fill counter

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  W  coefficient
in_valid  input  1  in_data valid
in_last  input  1  marks the final coefficient of a frame; sampled only on accept
in_ready  output  1  block can accept a coefficient
out_data  output  D*W  packed frame; coefficient k (k-th accepted, k=0..D-1) at bits [k*W +: W]
out_valid  output  1  out_data holds a complete frame
out_ready  input  1  downstream accepts the frame
err  output  1  sticky framing-error flag

Behaviour:
- One clock; reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Handshake definitions:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Reset values: in_ready=1, out_valid=0, out_data=0, err=0, count=0, fill_full=0, fill buffer=0.
- Reset mid-frame discards any partial or held frame.
- in_ready = !fill_full. It is purely registered and has no combinational path from out_ready.
- Fill side, on an input accept with count=c:
  - fill[c] <= in_data.
  - If c < D-1: count <= c+1.
  - If c == D-1: count <= 0 and the frame is complete.
- Frame transfer:
  - A complete frame moves to out_data at the same edge as the D-th accept if the output slot is free (out_valid==0 || out_ready==1). out_valid=1 on the next cycle, so latency is 1 cycle from the D-th accept.
  - If the slot is not free, the frame stays in the fill buffer, fill_full <= 1, and in_ready drops.
  - The held frame moves at the first edge where out_ready==1. At that edge fill_full <= 0 and out_valid stays 1 with the new data.
- Output transfer with no new frame pending: out_valid <= 0. out_data keeps its last value.
- While out_valid && !out_ready, out_data and out_valid are held stable.
- Throughput: one frame per D cycles sustained. With out_ready held high, in_ready never deasserts.
- Framing check, on input accept only:
  - in_last=1 with c < D-1 (early last): err <= 1. The partial frame is discarded (count <= 0, no output), so the block resynchronises.
  - in_last=0 with c == D-1 (missing last): the frame is emitted normally and err <= 1.
  - err is cleared only by rst.
- Simultaneous events:
  - D-th accept and output transfer in the same cycle: the new frame replaces the old at that edge and out_valid stays 1.
  - Early last and output transfer in the same cycle are independent.
- in_data, in_last and count do not change on cycles with no input accept.

Test Plan:
- Single frame: out_ready=1, feed 1..8 on consecutive cycles with in_last on 8 -> out_valid=1 exactly one cycle after the 8th accept; out_data[8:0]=1, out_data[17:9]=2, out_data[71:63]=8; err=0.
- Streaming: 16 coefficients 0..15 back-to-back, out_ready=1 -> in_ready stays 1 throughout; two one-cycle out_valid pulses 8 cycles apart carrying 0..7 then 8..15.
- Backpressure: out_ready=0, feed frame A (0x10..0x17) then frame B (0x20..0x27) -> after B's 8th accept in_ready=0 and out_data holds A stable. Raise out_ready for one cycle -> A transfers, next cycle out_data = B with out_valid=1, and in_ready=1.
- Early last: in_last on the 3rd coefficient -> err=1, no out_valid. The next 8 coefficients 0x30..0x37 with in_last on the 8th produce one frame with out_data[8:0]=0x30.
- Missing last: 8 coefficients with in_last=0 throughout -> frame emitted normally and err=1.
- Reset mid-frame: assert rst for 1 cycle after 5 accepts -> next cycle out_valid=0, out_data=0, err=0, in_ready=1. A following full frame 0x40..0x47 is emitted with slot 0 = 0x40.
